// File: rtl/btn_pulse_ctrl.sv
// btn_pulse_ctrl: conditions three raw push-buttons (load, inc, dec) into
// mutually exclusive single-cycle strobes for the 4-bit up/down load counter.
// Each channel: 2-flop synchronizer -> debounce counter -> rising-edge detect,
// then a registered priority arbiter (load > inc > dec).
// Optional feature: define AUTO_REPEAT_EN to enable auto-repeat on the inc
// and dec channels while their debounced level stays high.
module btn_pulse_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int DB_W          = 20
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int RPT_W         = 26
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_load,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       load_en,
  output logic       inc_en,
  output logic       dec_en,
  output logic [2:0] btn_level
);

  // Channel index: 2 = load, 1 = inc, 0 = dec (matches btn_level order).
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  logic [2:0]      raw;
  logic [2:0]      s1;
  logic [2:0]      s2;
  logic [2:0]      level;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      accept;
  logic [2:0]      press;
  logic [2:0]      req;

  assign raw       = {btn_load, btn_inc, btn_dec};
  assign btn_level = level;

  // Synchronize raw inputs and debounce each channel independently.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, giving a true two-flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      // NOTE: the counter array is only three small registers, so it is reset
      // like ordinary flops; a reset mid-debounce must abort the count.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          level[i]  <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press is raised on the same edge the debounced level goes 0->1.
  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    accept = '0;
    press  = '0;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (s2[i] != level[i]) && (db_cnt[i] == DB_MAX);
      press[i]  = accept[i] && s2[i];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_M1  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_M1 = RPT_W'(REPEAT_PERIOD - 1);

  // Repeat state for inc (index 1) and dec (index 0); load never repeats.
  // rpt_phase: 0 while waiting out the initial delay, 1 once periodic.
  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_phase;
  logic [1:0]       rpt_fire;

  // Fire a repeat request when the active interval has fully elapsed.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 2; i++) begin
      rpt_fire[i] = level[i] &&
                    (rpt_phase[i] ? (rpt_cnt[i] == RPT_PERIOD_M1)
                                  : (rpt_cnt[i] == RPT_DELAY_M1));
    end
  end

  // Repeat counters run while the level is held and clear when it drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_phase <= '0;
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!level[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign req = press | {1'b0, rpt_fire};
`else
  assign req = press;
`endif

  // Registered priority arbiter; lower-priority requests are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en <= 1'b0;
      inc_en  <= 1'b0;
      dec_en  <= 1'b0;
    end else begin
      load_en <= req[2];
      inc_en  <= !req[2] && req[1];
      dec_en  <= !req[2] && !req[1] && req[0];
    end
  end

endmodule
